// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO. Software
//            writes bytes to TXDATA; they are serialized LSB first on tx_o
//            once CTRL.tx_en is set.
// Ports    : clk_i            - system clock
//            resetn_i         - synchronous active-low reset
//            mem_addr_i       - byte address from the core
//            mem_read_en_i    - read request
//            mem_read_data_o  - registered read data (1-cycle latency)
//            mem_write_en_i   - write request
//            mem_write_data_i - write data
//            tx_o             - serial line, idle high
//            irq_o            - level interrupt: enabled, FIFO empty, idle
// Register map (offset from BASE_ADDR, addr[1:0] ignored):
//            0x0 CTRL     bit0 tx_en, bit1 fifo_clr (write-1, reads 0)
//            0x4 TXDATA   write pushes [7:0], reads 0
//            0x8 STATUS   bit0 empty, bit1 full, bit2 busy,
//                         bit3 overflow (W1C), [15:8] FIFO count
//            0xC BAUD_DIV [15:0] clocks per bit, 0 behaves as 1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_mmio #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  BASE_ADDR    = 32'hA000_0000,
    parameter int               FIFO_DEPTH   = 16,
    parameter int               CLKS_PER_BIT = 868
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mem_read_en_i,
    output logic [XLEN-1:0] mem_read_data_o,
    input  logic            mem_write_en_i,
    input  logic [XLEN-1:0] mem_write_data_i,
    output logic            tx_o,
    output logic            irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RST  = 16'(CLKS_PER_BIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            tx_en_q;
    logic            ovf_q;
    logic [15:0]     baud_q;
    logic [XLEN-1:0] rdata_q;
    logic            irq_q;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic [1:0]      state_q, state_d;
    logic [15:0]     cnt_q,   cnt_d;     // cycles left in the current bit
    logic [15:0]     div_q,   div_d;     // divisor latched at START
    logic [2:0]      bit_q,   bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q,    tx_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_hit;
    logic [1:0] w_sel;
    logic       w_wr;
    logic       w_ctrl_wr, w_clr, w_push_req, w_stat_wr, w_baud_wr;

    assign w_hit      = (mem_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign w_sel      = mem_addr_i[3:2];
    assign w_wr       = mem_write_en_i && w_hit;
    assign w_ctrl_wr  = w_wr && (w_sel == REG_CTRL);
    assign w_clr      = w_ctrl_wr && mem_write_data_i[1];
    assign w_push_req = w_wr && (w_sel == REG_TXDATA);
    assign w_stat_wr  = w_wr && (w_sel == REG_STATUS);
    assign w_baud_wr  = w_wr && (w_sel == REG_BAUD);

    // Byte-lane bits and upper data bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{mem_addr_i[1:0], mem_write_data_i[XLEN-1:16]};

    // ------------------------------------------------------------------
    // FIFO status and push/pop qualification
    // ------------------------------------------------------------------
    logic        w_empty, w_full, w_pop, w_push, w_ovf_set, w_start_ok;
    logic [15:0] w_baud_eff;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == DEPTH_CNT);
    assign w_start_ok = tx_en_q && !w_empty;
    assign w_baud_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;

    // A push into a full FIFO survives only if the FSM pops the same cycle.
    // A clear in the same cycle always discards the push without flagging it.
    assign w_push    = w_push_req && !w_clr && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && !w_clr && w_full && !w_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) fifo_mem[wr_ptr_q] <= mem_write_data_i[7:0];
    end

    // ------------------------------------------------------------------
    // TX state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_pop   = 1'b1;
                    state_d = ST_START;
                    shift_d = fifo_mem[rd_ptr_q];
                    cnt_d   = w_baud_eff;
                    div_d   = w_baud_eff;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = div_q;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd1) begin
                    cnt_d   = div_q;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin // ST_STOP
                if (cnt_q == 16'd1) begin
                    // Chain straight into the next START so frames abut.
                    if (w_start_ok) begin
                        w_pop   = 1'b1;
                        state_d = ST_START;
                        shift_d = fifo_mem[rd_ptr_q];
                        cnt_d   = w_baud_eff;
                        div_d   = w_baud_eff;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    // Line level follows the next state so tx_o is a clean register output.
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux (pre-write register values)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_rd_val;

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            REG_CTRL:   w_rd_val[0] = tx_en_q;
            REG_STATUS: begin
                w_rd_val[0]    = w_empty;
                w_rd_val[1]    = w_full;
                w_rd_val[2]    = (state_q != ST_IDLE);
                w_rd_val[3]    = ovf_q;
                w_rd_val[15:8] = 8'(count_q);
            end
            REG_BAUD:   w_rd_val[15:0] = baud_q;
            default:    w_rd_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            tx_en_q  <= 1'b0;
            ovf_q    <= 1'b0;
            baud_q   <= BAUD_RST;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            div_q    <= 16'd1;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            if (w_ctrl_wr) tx_en_q <= mem_write_data_i[0];
            if (w_baud_wr) baud_q  <= mem_write_data_i[15:0];

            if (w_ovf_set)                           ovf_q <= 1'b1;
            else if (w_stat_wr && mem_write_data_i[3]) ovf_q <= 1'b0;

            if (mem_read_en_i) rdata_q <= w_hit ? w_rd_val : '0;

            irq_q    <= tx_en_q && w_empty && (state_q == ST_IDLE);

            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign mem_read_data_o = rdata_q;
    assign tx_o            = tx_q;
    assign irq_o           = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ============================================================================
// Module   : tb_uart_tx_mmio
// Purpose  : Directed self-checking bench for uart_tx_mmio.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_mmio;

    localparam logic [31:0] A_CTRL   = 32'hA000_0000;
    localparam logic [31:0] A_TXDATA = 32'hA000_0004;
    localparam logic [31:0] A_STATUS = 32'hA000_0008;
    localparam logic [31:0] A_BAUD   = 32'hA000_000C;
    localparam logic [31:0] A_MISS   = 32'h9000_0004;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic        rd_en;
    logic [31:0] rdata;
    logic        wr_en;
    logic [31:0] wdata;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_mmio #(
        .XLEN         (32),
        .BASE_ADDR    (32'hA000_0000),
        .FIFO_DEPTH   (16),
        .CLKS_PER_BIT (868)
    ) dut (
        .clk_i            (clk),
        .resetn_i         (resetn),
        .mem_addr_i       (addr),
        .mem_read_en_i    (rd_en),
        .mem_read_data_o  (rdata),
        .mem_write_en_i   (wr_en),
        .mem_write_data_i (wdata),
        .tx_o             (tx),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        addr  = 32'h0;
        d     = rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Samples one 8N1 frame cycle by cycle. With immediate=1 the frame must
    // begin on the current falling edge (no idle gap allowed).
    task automatic rx_frame(input int div, input bit immediate,
                            input logic [7:0] exp_byte, input string tag);
        logic [9:0] pat;
        logic [7:0] got;
        int errs;
        int waited;
        int k;
        pat    = {1'b1, exp_byte, 1'b0};
        got    = 8'h00;
        errs   = 0;
        waited = 0;
        if (!immediate) begin
            while (tx !== 1'b0 && waited < 3000) begin
                @(negedge clk);
                waited++;
            end
        end
        if (tx !== 1'b0) begin
            check({tag, " start"}, {31'd0, tx}, 32'd0);
            return;
        end
        for (int i = 0; i < 10 * div; i++) begin
            k = i / div;
            if (tx !== pat[k]) errs++;
            if (k >= 1 && k <= 8 && (i % div) == div / 2) got[k-1] = tx;
            @(negedge clk);
        end
        check({tag, " timing"}, errs, 32'd0);
        check({tag, " byte"}, {24'd0, got}, {24'd0, exp_byte});
    endtask

    task automatic expect_idle(input int n, input string tag);
        int errs;
        errs = 0;
        repeat (n) begin
            if (tx !== 1'b1) errs++;
            @(negedge clk);
        end
        check(tag, errs, 32'd0);
    endtask

    logic [7:0] hello [12];
    logic [31:0] tmp;

    initial begin
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                  8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
        resetn = 1'b0;
        addr   = 32'h0;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        wdata  = 32'h0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst tx", {31'd0, tx}, 32'd1);
        check("rst irq", {31'd0, irq}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        read_check("rst status", A_STATUS, 32'h0000_0001);
        read_check("rst baud", A_BAUD, 32'd868);
        read_check("rst ctrl", A_CTRL, 32'd0);

        // Single frame, BAUD_DIV=4, byte 0x48
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TXDATA, 32'h48);
        bus_write(A_CTRL, 32'h1);
        rx_frame(4, 1'b0, 8'h48, "frame48");
        check("post-stop tx", {31'd0, tx}, 32'd1);
        check("irq before rise", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq after stop", {31'd0, irq}, 32'd1);

        // "Hello World!" back to back at BAUD_DIV=2
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd2);
        for (int i = 0; i < 12; i++) bus_write(A_TXDATA, {24'd0, hello[i]});
        read_check("hello count12", A_STATUS, 32'h0000_0C00);
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i < 12; i++) rx_frame(2, (i != 0), hello[i], $sformatf("hello%0d", i));
        read_check("hello drained", A_STATUS, 32'h0000_0001);

        // Overflow: 17 pushes into a 16-entry FIFO, then drain at BAUD_DIV=0
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 16; i++) bus_write(A_TXDATA, 32'h10 + i);
        bus_write(A_TXDATA, 32'hEE);
        read_check("ovf status", A_STATUS, 32'h0000_100A);
        bus_write(A_STATUS, 32'h8);
        read_check("ovf cleared", A_STATUS, 32'h0000_1002);
        bus_write(A_BAUD, 32'd0);
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i < 16; i++) rx_frame(1, (i != 0), 8'(8'h10 + i), $sformatf("ovf%0d", i));
        expect_idle(40, "no 17th byte");
        read_check("ovf drained", A_STATUS, 32'h0000_0001);

        // fifo_clr mid-frame with 3 bytes queued
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TXDATA, 32'h55);
        bus_write(A_TXDATA, 32'h01);
        bus_write(A_TXDATA, 32'h02);
        bus_write(A_TXDATA, 32'h03);
        bus_write(A_CTRL, 32'h1);
        fork
            rx_frame(4, 1'b0, 8'h55, "clr frame");
            begin
                repeat (8) @(negedge clk);
                bus_write(A_CTRL, 32'h3);
            end
        join
        expect_idle(60, "after clr");
        read_check("clr status", A_STATUS, 32'h0000_0001);
        read_check("clr ctrl", A_CTRL, 32'h0000_0001);

        // Reset mid-frame
        bus_write(A_TXDATA, 32'h00);
        begin
            int w;
            w = 0;
            while (tx !== 1'b0 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("rst-frame start", {31'd0, tx}, 32'd0);
        end
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst mid tx", {31'd0, tx}, 32'd1);
        check("rst mid irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        read_check("rst2 ctrl", A_CTRL, 32'd0);
        read_check("rst2 status", A_STATUS, 32'h0000_0001);
        read_check("rst2 baud", A_BAUD, 32'd868);

        // Decode misses and byte-lane aliasing
        bus_write(A_MISS, 32'h77);
        read_check("pre-miss baud", A_BAUD, 32'd868);
        read_check("miss read", A_MISS, 32'd0);
        read_check("miss status", A_STATUS, 32'h0000_0001);
        bus_write(32'hA000_0005, 32'h5A);
        read_check("sb push", A_STATUS, 32'h0000_0100);
        read_check("txdata reads0", A_TXDATA, 32'd0);

        // Simultaneous read and write of BAUD_DIV returns the old value
        addr  = A_BAUD;
        wdata = 32'd7;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        tmp   = rdata;
        check("rw old value", tmp, 32'd868);
        read_check("rw new value", A_BAUD, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
